// File: rtl/set_job_scheduler_if.sv
// Request, engine and response signals of set_job_scheduler.
// slave is the scheduler's view; master is the surrounding environment.
interface set_job_scheduler_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [23:0] req0_central;
  logic [11:0] req0_radius;
  logic [1:0]  req0_mode;

  logic        req1_valid;
  logic        req1_ready;
  logic [23:0] req1_central;
  logic [11:0] req1_radius;
  logic [1:0]  req1_mode;

  logic        set_en;
  logic [23:0] set_central;
  logic [11:0] set_radius;
  logic [1:0]  set_mode;
  logic        set_valid;
  logic [7:0]  set_candidate;

  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [7:0]  rsp_candidate;
  logic        rsp_timeout;

  modport slave (
    input  req0_valid, req0_central, req0_radius, req0_mode,
    input  req1_valid, req1_central, req1_radius, req1_mode,
    output req0_ready, req1_ready,
    output set_en, set_central, set_radius, set_mode,
    input  set_valid, set_candidate,
    output rsp_valid, rsp_id, rsp_candidate, rsp_timeout,
    input  rsp_ready
  );

  modport master (
    output req0_valid, req0_central, req0_radius, req0_mode,
    output req1_valid, req1_central, req1_radius, req1_mode,
    input  req0_ready, req1_ready,
    input  set_en, set_central, set_radius, set_mode,
    output set_valid, set_candidate,
    input  rsp_valid, rsp_id, rsp_candidate, rsp_timeout,
    output rsp_ready
  );
endinterface

// File: rtl/set_job_scheduler.sv
// Round-robin front end sharing one circle-set counting engine between two requesters,
// with a watchdog that aborts jobs whose engine never reports completion.
module set_job_scheduler #(
  parameter int unsigned TIMEOUT = 80
) (
  input logic                clk,
  input logic                rst,
  set_job_scheduler_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StLaunch, StRun, StResp} state_e;

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q;
  logic [23:0] central_q;
  logic [11:0] radius_q;
  logic [1:0]  mode_q;
  logic        cur_id_q;
  logic        last_id_q;
  logic        set_en_q;
  logic [7:0]  cnt_q;
  logic        rsp_valid_q;
  logic [7:0]  rsp_cand_q;
  logic        rsp_timeout_q;

  logic grant1;
  logic rdy0;
  logic rdy1;

  // On a tie the requester that was not served last wins.
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_id_q);
  // Gated by rst so every output reads 0 while reset is held.
  assign rdy0   = rst & (state_q == StIdle) & bus.req0_valid & ~grant1;
  assign rdy1   = rst & (state_q == StIdle) & grant1;

  assign bus.req0_ready    = rdy0;
  assign bus.req1_ready    = rdy1;
  assign bus.set_en        = set_en_q;
  assign bus.set_central   = central_q;
  assign bus.set_radius    = radius_q;
  assign bus.set_mode      = mode_q;
  assign bus.rsp_valid     = rsp_valid_q;
  assign bus.rsp_id        = cur_id_q;
  assign bus.rsp_candidate = rsp_cand_q;
  assign bus.rsp_timeout   = rsp_timeout_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StIdle;
      central_q     <= '0;
      radius_q      <= '0;
      mode_q        <= '0;
      cur_id_q      <= 1'b0;
      last_id_q     <= 1'b1;
      set_en_q      <= 1'b0;
      cnt_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_cand_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rdy0 | rdy1) begin
            central_q <= grant1 ? bus.req1_central : bus.req0_central;
            radius_q  <= grant1 ? bus.req1_radius  : bus.req0_radius;
            mode_q    <= grant1 ? bus.req1_mode    : bus.req0_mode;
            cur_id_q  <= grant1;
            set_en_q  <= 1'b1;
            state_q   <= StLaunch;
          end
        end
        StLaunch: begin
          set_en_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= StRun;
        end
        StRun: begin
          cnt_q <= cnt_q + 8'd1;
          // A result arriving on the watchdog's last cycle still counts as success.
          if (bus.set_valid) begin
            rsp_cand_q    <= bus.set_candidate;
            rsp_timeout_q <= 1'b0;
            rsp_valid_q   <= 1'b1;
            state_q       <= StResp;
          end else if (cnt_q == CntLast) begin
            rsp_cand_q    <= '0;
            rsp_timeout_q <= 1'b1;
            rsp_valid_q   <= 1'b1;
            state_q       <= StResp;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            last_id_q   <= cur_id_q;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/set_job_scheduler.md
# set_job_scheduler

Front-end controller that shares one circle-set counting engine between two requesters. It arbitrates job requests round-robin and launches the engine with a one-cycle `set_en` pulse. It holds the job's operands stable while the engine runs, captures the candidate count on `set_valid`, and returns a tagged response. A watchdog aborts jobs whose engine never reports completion.

## Interface
Parameters:
- `TIMEOUT`, default 80: maximum RUN cycles allowed before a job is aborted. The engine's nominal completion is about 66 cycles after `en`. Legal range is 2..255.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `req0_valid` / `req1_valid`  in  1  requester has a job pending.
- `req0_ready` / `req1_ready`  out  1  job accepted this cycle when both valid and ready are high.
- `req0_central` / `req1_central`  in  24  three 8-bit circle centres, each {x[3:0], y[3:0]}, circle 1 in the MSBs.
- `req0_radius` / `req1_radius`  in  12  three 4-bit radii.
- `req0_mode` / `req1_mode`  in  2  set-operation mode.
- `set_en`  out  1  one-cycle launch pulse to the engine.
- `set_central`  out  24  operands driven to the engine.
- `set_radius`  out  12  operands driven to the engine.
- `set_mode`  out  2  operands driven to the engine.
- `set_valid`  in  1  engine result strobe.
- `set_candidate`  in  8  engine count.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  1  index of the requester that issued the job.
- `rsp_candidate`  out  8  captured count.
- `rsp_timeout`  out  1  job was aborted by the watchdog.

## Operation
- FSM states: IDLE, LAUNCH, RUN, RESP. Encoding is free; IDLE is the reset state.
- IDLE, arbitration:
  - Grant goes to the only valid requester.
  - If both are valid, grant goes to the requester not in `last_id`.
  - `reqN_ready` is combinational: high only in IDLE and only for the granted requester.
- IDLE, handshake:
  - On the accepting edge, latch central/radius/mode into a job register and latch the grant into `cur_id`.
  - Go to LAUNCH.
- LAUNCH:
  - Drive `set_en` = 1 for exactly this cycle.
  - Clear the watchdog counter to 0.
  - Go to RUN.
- RUN:
  - Counter (8 bit) increments every cycle.
  - If `set_valid` = 1: capture `set_candidate` into `rsp_candidate`, clear `rsp_timeout`, go to RESP.
  - Otherwise, if counter == TIMEOUT-1: set `rsp_candidate` = 0 and `rsp_timeout` = 1, go to RESP.
  - If `set_valid` and the timeout coincide, `set_valid` wins (no timeout).
- RESP:
  - `rsp_valid` = 1; `rsp_id` = `cur_id`.
  - When `rsp_ready` = 1: update `last_id` ← `cur_id` and go to IDLE.
  - `rsp_*` outputs stay stable until accepted.
- `set_central`, `set_radius` and `set_mode` are driven from the job register at all times. They change only on an IDLE handshake.
- `set_valid` is ignored in IDLE, LAUNCH and RESP.
- `req*` operand inputs are sampled only on the accepting edge; changes while not ready have no effect.

## Timing
- Reset (`rst` = 0, asynchronous):
  - State = IDLE; `last_id` = 1, so req0 wins the first tie.
  - `set_en`, `rsp_valid`, `rsp_id`, `rsp_candidate`, `rsp_timeout` = 0; job register = 0; counter = 0.
- Reset mid-job: the engine result is abandoned and no response is issued. Release takes effect at the first rising edge after deassertion.
- Accept edge T:
  - `set_en` is high in cycle T+1.
  - RUN begins in cycle T+2.
- Response timing:
  - `set_valid` sampled high at edge E → `rsp_valid` high from E+1.
  - With no `set_valid`, `rsp_valid` with `rsp_timeout` rises TIMEOUT+1 cycles after the `set_en` cycle.
- Response-accept edge R: IDLE from R+1. A waiting requester is accepted at R+1 at the earliest, with `set_en` at R+2.
- Only one job is in flight; there is no queueing beyond the requester's own valid/ready hold.
- Back-pressure: `rsp_ready` held low keeps RESP indefinitely. `reqN_ready` stays low throughout.

## Test plan
- Single job: req0 central=24'h226_4A3 style operands (x1=2,y1=2), radius=12'h300, mode=0; engine model returns `set_valid` with candidate=8'd12 → `set_en` exactly one cycle after accept; `rsp_valid` with `rsp_id`=0, `rsp_candidate`=12, `rsp_timeout`=0.
- Contention: req0 and req1 valid continuously; `rsp_ready` tied 1 → grants alternate 0,1,0,1 and first grant is 0 after reset; each response's id and count match its job.
- Watchdog: engine model never asserts `set_valid`, TIMEOUT=80 → response 81 cycles after `set_en` with `rsp_timeout`=1, `rsp_candidate`=0; the next job runs normally.
- Coincidence: `set_valid` arrives exactly when counter == TIMEOUT-1 → `rsp_timeout`=0 and `rsp_candidate` = engine value.
- Back-pressure: hold `rsp_ready`=0 for 20 cycles with req1 pending → `rsp_*` stable, `req1_ready`=0 throughout; req1 is accepted one cycle after `rsp_ready`.
- Reset mid-RUN: assert `rst`=0 forty cycles into a job → all outputs 0 immediately, no response; after release, req1 and req0 both valid → req0 granted first.
